// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment readback path: active-low segment
// patterns (bits 6:0 = g..a), special digit codes and the scan FSM state type.
package sseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIG_BLANK   = 4'hA;
  localparam logic [3:0] DIG_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational inverse of the digit-to-segment encoder: 7-bit active-low
// pattern to 4-bit digit code, with valid low for any pattern outside the table.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       valid
);

  always_comb begin
    code  = DIG_INVALID;
    valid = 1'b1;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = DIG_BLANK;
      default: begin
        code  = DIG_INVALID;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Watches a multiplexed 7-segment bus, waits for each strobed pattern to settle,
// decodes it and publishes a complete frame once every digit position has been seen.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_DIGITS-1:0]     an,
  input  logic [7:0]                sseg,
  input  logic                      clr_err,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     dp,
  output logic                      frame_valid,
  output logic                      seg_err,
  output logic                      err_sticky,
  output logic                      an_err
);

  localparam int                    SW       = NUM_DIGITS + 8;
  localparam logic [CNT_W-1:0]      STABLE   = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  logic [SW-1:0]                    sample_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [CNT_W-1:0]                 cnt_inc;
  state_t                           state_q;
  state_t                           state_d;
  logic                             changed;
  logic                             capture;

  logic [NUM_DIGITS-1:0]            an_low;
  logic                             multi_low;
  logic [7:0]                       seg_s;
  logic [3:0]                       dec_code;
  logic                             dec_valid;

  logic [NUM_DIGITS-1:0][3:0]       hold_q;
  logic [NUM_DIGITS-1:0][3:0]       hold_d;
  logic [NUM_DIGITS-1:0]            hold_dp_q;
  logic [NUM_DIGITS-1:0]            hold_dp_d;
  logic [NUM_DIGITS-1:0]            mask_q;
  logic [NUM_DIGITS-1:0]            mask_d;
  logic                             frame_load;
  logic                             seg_err_d;
  logic                             an_err_d;

  // A change is detected as the new sample is registered, so a pattern first
  // registered at edge E0 reaches STABLE_CYCLES identical samples at E(STABLE_CYCLES-1).
  assign changed = ({an, sseg} != sample_q);
  assign an_low  = ~sample_q[SW-1:8];
  assign seg_s   = sample_q[7:0];
  assign multi_low = ((an_low & (an_low - AN_ONE)) != '0);

  sseg_pattern_decode u_decode (
    .pattern (seg_s[6:0]),
    .code    (dec_code),
    .valid   (dec_valid)
  );

  always_comb begin
    cnt_inc = (cnt_q == STABLE) ? cnt_q : cnt_q + CNT_ONE;
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE:   if (changed) state_d = SETTLE;
      SETTLE: begin
        if (!changed && cnt_inc == STABLE) begin
          state_d = HOLD;
          capture = 1'b1;
        end
      end
      HOLD:   if (changed) state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d     = hold_q;
    hold_dp_d  = hold_dp_q;
    mask_d     = mask_q;
    frame_load = 1'b0;
    seg_err_d  = 1'b0;
    an_err_d   = 1'b0;
    if (capture) begin
      if (multi_low) begin
        an_err_d = 1'b1;
      end else if (an_low != '0) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (an_low[i]) begin
            hold_d[i]    = dec_code;
            hold_dp_d[i] = ~seg_s[7];
          end
        end
        seg_err_d = ~dec_valid;
        if ((mask_q | an_low) == '1) begin
          frame_load = 1'b1;
          mask_d     = '0;
        end else begin
          mask_d = mask_q | an_low;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q    <= '1;
      cnt_q       <= '0;
      state_q     <= IDLE;
      hold_q      <= {NUM_DIGITS{DIG_BLANK}};
      hold_dp_q   <= '0;
      mask_q      <= '0;
      digits      <= {NUM_DIGITS{DIG_BLANK}};
      dp          <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      an_err      <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      sample_q    <= {an, sseg};
      cnt_q       <= changed ? CNT_ONE : cnt_inc;
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_dp_q   <= hold_dp_d;
      mask_q      <= mask_d;
      frame_valid <= frame_load;
      seg_err     <= seg_err_d;
      an_err      <= an_err_d;
      if (frame_load) begin
        digits <= hold_d;
        dp     <= hold_dp_d;
      end
      // A new error in the same cycle as a clear keeps the flag set.
      if (seg_err_d || an_err_d) err_sticky <= 1'b1;
      else if (clr_err)          err_sticky <= 1'b0;
    end
  end

endmodule
